fp_csr_unit: RTL
================

Name: fp_csr_unit

Overview:
- Floating-point control/status register block for the RV32 F pipeline.
- Sits downstream of the FP execute units (compare, add, mul, div, convert). Accumulates their exception flags into fflags at writeback; the compare unit's invalid output maps to NV.
- Serves Zicsr accesses to fflags, frm and fcsr, and drives the dynamic rounding mode back to the FP units.

Parameters:
- XLEN, 32, CSR data width.
- FLAGS_W, 5, width of the exception flag vector {NV,DZ,OF,UF,NX}.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- fp_valid_i  input  1  an FP instruction retires this cycle
- fp_flags_i  input  5  flags of the retiring FP op; bit4=NV, 3=DZ, 2=OF, 1=UF, 0=NX
- csr_valid_i  input  1  CSR instruction request
- csr_op_i  input  2  00=none, 01=RW, 10=RS (set), 11=RC (clear)
- csr_addr_i  input  12  CSR address
- csr_wdata_i  input  32  rs1 or zimm value, already zero-extended
- flush_i  input  1  kill the request in flight; no architectural update this cycle
- csr_rdata_o  output  32  old CSR value, registered
- csr_rvalid_o  output  1  one-cycle pulse; csr_rdata_o/csr_illegal_o valid
- csr_illegal_o  output  1  address not 0x001/0x002/0x003, or csr_op_i=00 with csr_valid_i
- frm_o  output  3  current dynamic rounding mode
- frm_invalid_o  output  1  frm_o is 5, 6 or 7 (reserved); FP units raise illegal-instruction on dynamic rm
- fflags_o  output  5  current accumulated flags

Behaviour:
Reset and state:
- Synchronous active-high reset. When rst=1 at a clk edge: fflags=0, frm=0, csr_rdata_o=0, csr_rvalid_o=0, csr_illegal_o=0, state=IDLE.
- Reset overrides every other input in the same cycle, including a request mid-operation.

FSM:
- IDLE: on csr_valid_i=1 and flush_i=0, latch the result, go to RESP.
- RESP: drive csr_rvalid_o=1 for exactly one cycle, then return to IDLE.
- A csr_valid_i arriving while in RESP is accepted and processed identically, so back-to-back requests yield rvalid on consecutive cycles.
- flush_i=1 in the same cycle as csr_valid_i: request dropped. No state change, no rvalid.

Accumulation:
- Every cycle with fp_valid_i=1 and flush_i=0: fflags <= fflags | fp_flags_i.
- Accumulation is sticky. Only a CSR write or reset clears flags.

CSR read:
- Old value per address, taken from the pre-write state with same-cycle FP flags bypassed in: F = fflags | (fp_valid_i ? fp_flags_i : 0).
- 0x001 reads {27'b0, F}.
- 0x002 reads {29'b0, frm}.
- 0x003 reads {24'b0, frm, F}.
- Registered result appears on csr_rdata_o with csr_rvalid_o one cycle after acceptance.

CSR write:
- Applied at the acceptance edge, using base value B (same layout as the read above):
  - RW: new = wdata.
  - RS: new = B | wdata.
  - RC: new = B & ~wdata.
- 0x001: fflags <= new[4:0].
- 0x002: frm <= new[2:0].
- 0x003: frm <= new[7:5], fflags <= new[4:0].
- Upper bits of wdata are ignored (WARL-zero).
- RS or RC with wdata=0 performs no write, but the F bypass is still committed to fflags.

Ordering and simultaneous events:
- The retiring FP op is older than the CSR instruction.
- A same-cycle RW to fflags therefore overwrites the just-accumulated flags.
- RS/RC operate on the merged value F.

Illegal requests:
- csr_illegal_o=1 with rvalid.
- rdata=0, and no CSR write occurs.
- FP flag accumulation still occurs.

Outputs and latency:
- frm_o, fflags_o and frm_invalid_o reflect registers directly, with no extra latency.
- A new frm is visible on frm_o the cycle after the write edge.

Test Plan:
1. Reset, then fp_valid_i=1 with fp_flags_i=5'b10000 (compare on sNaN) for one cycle -> fflags_o=5'h10 next cycle; read 0x001 -> csr_rdata_o=0x10 with one rvalid pulse.
2. fflags=0x10; same cycle fp_valid_i=1, fp_flags_i=0x01, CSR RW 0x001 wdata=0x04 -> rdata=0x11, fflags_o=0x04 afterwards.
3. RW 0x003 wdata=0xFFFFFFFF -> frm_o=7, frm_invalid_o=1, fflags_o=0x1F; then RC 0x002 wdata=0x4 -> rdata=7, frm_o=3, frm_invalid_o=0.
4. Read 0x004 -> csr_illegal_o=1, rdata=0, all state unchanged; then csr_valid_i+flush_i with RW 0x001 wdata=0x1F -> no rvalid, fflags unchanged.
5. Back-to-back RS 0x001 wdata=0x02 then RS 0x001 wdata=0x08 on consecutive cycles from fflags=0 -> rvalid two consecutive cycles, rdata 0x00 then 0x02, final fflags_o=0x0A.
6. rst asserted the cycle a RW 0x003 wdata=0xE5 is presented -> next cycle fflags_o=0, frm_o=0, csr_rvalid_o=0.

Source files
------------

// File: rtl/fp_csr_if.sv
// Bus between the FP CSR block and the pipeline. It carries the FP writeback
// flag stream, the Zicsr request/response and the rounding-mode outputs.
interface fp_csr_if #(
  parameter int XLEN    = 32,
  parameter int FLAGS_W = 5
);
  logic               fp_valid_i;
  logic [FLAGS_W-1:0] fp_flags_i;
  logic               csr_valid_i;
  logic [1:0]         csr_op_i;
  logic [11:0]        csr_addr_i;
  logic [XLEN-1:0]    csr_wdata_i;
  logic               flush_i;
  logic [XLEN-1:0]    csr_rdata_o;
  logic               csr_rvalid_o;
  logic               csr_illegal_o;
  logic [2:0]         frm_o;
  logic               frm_invalid_o;
  logic [FLAGS_W-1:0] fflags_o;

  // Pipeline side: drives retirements and CSR requests.
  modport master (
    output fp_valid_i, fp_flags_i, csr_valid_i, csr_op_i, csr_addr_i,
           csr_wdata_i, flush_i,
    input  csr_rdata_o, csr_rvalid_o, csr_illegal_o, frm_o, frm_invalid_o,
           fflags_o
  );

  // CSR block side.
  modport slave (
    input  fp_valid_i, fp_flags_i, csr_valid_i, csr_op_i, csr_addr_i,
           csr_wdata_i, flush_i,
    output csr_rdata_o, csr_rvalid_o, csr_illegal_o, frm_o, frm_invalid_o,
           fflags_o
  );
endinterface

// File: rtl/fp_csr_unit.sv
// Floating-point CSR block: accumulates FP exception flags into fflags,
// serves Zicsr accesses to fflags/frm/fcsr and exports the dynamic rounding
// mode. The retiring FP op is treated as older than a same-cycle CSR access,
// so its flags are merged into the base value before the CSR op is applied.
module fp_csr_unit #(
  parameter int XLEN    = 32,
  parameter int FLAGS_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  fp_csr_if.slave  bus
);

  localparam int CSR_BITS = FLAGS_W + 3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] A_FFLAGS = 12'h001;
  localparam logic [11:0] A_FRM    = 12'h002;
  localparam logic [11:0] A_FCSR   = 12'h003;

  logic [0:0]          state_q, state_d;
  logic [FLAGS_W-1:0]  fflags_q, fflags_d;
  logic [2:0]          frm_q, frm_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                illegal_q;

  logic [FLAGS_W-1:0]  f_merged;
  logic [CSR_BITS-1:0] base_val;
  logic [CSR_BITS-1:0] new_val;
  logic                accept;
  logic                illegal;
  logic                do_write;

  // Merge same-cycle FP flags, compute the CSR base/new values and next state.
  always_comb begin
    f_merged = fflags_q | (bus.fp_valid_i ? bus.fp_flags_i : '0);
    accept   = bus.csr_valid_i && !bus.flush_i;

    illegal  = (bus.csr_op_i == OP_NONE) ||
               !((bus.csr_addr_i == A_FFLAGS) || (bus.csr_addr_i == A_FRM) ||
                 (bus.csr_addr_i == A_FCSR));

    base_val = '0;
    case (bus.csr_addr_i)
      A_FFLAGS: base_val = {3'b000, f_merged};
      A_FRM:    base_val = {{FLAGS_W{1'b0}}, frm_q};
      A_FCSR:   base_val = {frm_q, f_merged};
      default:  base_val = '0;
    endcase

    new_val = base_val;
    case (bus.csr_op_i)
      OP_RW:   new_val = bus.csr_wdata_i[CSR_BITS-1:0];
      OP_RS:   new_val = base_val | bus.csr_wdata_i[CSR_BITS-1:0];
      OP_RC:   new_val = base_val & ~bus.csr_wdata_i[CSR_BITS-1:0];
      default: new_val = base_val;
    endcase

    // Set/clear with a zero mask is a pure read: no write side effect.
    do_write = accept && !illegal &&
               ((bus.csr_op_i == OP_RW) || (bus.csr_wdata_i != '0));

    // Flag accumulation is independent of the CSR request, but a flush kills it.
    fflags_d = (bus.fp_valid_i && !bus.flush_i) ? f_merged : fflags_q;
    frm_d    = frm_q;
    if (do_write) begin
      case (bus.csr_addr_i)
        A_FFLAGS: fflags_d = new_val[FLAGS_W-1:0];
        A_FRM:    frm_d    = new_val[2:0];
        A_FCSR: begin
          frm_d    = new_val[CSR_BITS-1:FLAGS_W];
          fflags_d = new_val[FLAGS_W-1:0];
        end
        default: ;
      endcase
    end

    rdata_d = illegal ? '0 : {{(XLEN-CSR_BITS){1'b0}}, base_val};
    // An accepted request in RESP re-enters RESP, giving back-to-back pulses.
    state_d = accept ? S_RESP : S_IDLE;
  end

  // Architectural registers, response latch and FSM; reset overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fflags_q  <= '0;
      frm_q     <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
      if (accept) begin
        rdata_q   <= rdata_d;
        illegal_q <= illegal;
      end
    end
  end

  assign bus.csr_rvalid_o  = (state_q == S_RESP);
  assign bus.csr_rdata_o   = rdata_q;
  assign bus.csr_illegal_o = illegal_q;
  assign bus.frm_o         = frm_q;
  assign bus.frm_invalid_o = (frm_q >= 3'd5);
  assign bus.fflags_o      = fflags_q;

endmodule
